// File: rtl/booth_mul_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: FSM encodings and
// the iteration counter width helper.
package booth_mul_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CALC    = 2'b01,
    DONE    = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/booth_mul_step.sv
// One combinational Booth iteration: conditional add/subtract of the
// multiplicand followed by an arithmetic right shift of {A,Q,q_1}.
module booth_step #(
  parameter int n = 5
) (
  input  logic [n:0]   acc,
  input  logic [n-1:0] q,
  input  logic         q_1,
  input  logic [n:0]   m,
  output logic [n:0]   acc_next,
  output logic [n-1:0] q_next,
  output logic         q_1_next
);

  logic [n:0] sum;

  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
  end

  // Arithmetic shift: the accumulator sign bit is replicated into the MSB.
  assign acc_next = {sum[n], sum[n:1]};
  assign q_next   = {sum[0], q[n-1:1]};
  assign q_1_next = q[0];

endmodule

// File: rtl/booth_mul.sv
// Sequential radix-2 Booth multiplier. Releasing rst launches one signed
// n x n multiplication; the 2n-bit product is held in DONE until rst returns.
module booth_mul
  import booth_mul_pkg::*;
#(
  parameter int n = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  output logic [2*n-1:0] product,
  output logic [1:0]     state
);

  localparam int CW = count_width(n);

  state_t          state_reg;
  logic [2*n-1:0]  product_reg;
  logic [n:0]      acc_reg;
  logic [n:0]      m_reg;
  logic [n-1:0]    q_reg;
  logic            q_1_reg;
  logic [CW-1:0]   count_reg;

  logic [n:0]      acc_next;
  logic [n-1:0]    q_next;
  logic            q_1_next;

  booth_step #(.n(n)) u_step (
    .acc      (acc_reg),
    .q        (q_reg),
    .q_1      (q_1_reg),
    .m        (m_reg),
    .acc_next (acc_next),
    .q_next   (q_next),
    .q_1_next (q_1_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      product_reg <= '0;
      acc_reg     <= '0;
      m_reg       <= '0;
      q_reg       <= '0;
      q_1_reg     <= 1'b0;
      count_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Operands are captured only here; later changes on a/b are ignored.
          m_reg     <= {a[n-1], a};
          q_reg     <= b;
          acc_reg   <= '0;
          q_1_reg   <= 1'b0;
          count_reg <= CW'(n);
          state_reg <= CALC;
        end
        CALC: begin
          acc_reg   <= acc_next;
          q_reg     <= q_next;
          q_1_reg   <= q_1_next;
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            product_reg <= {acc_next[n-1:0], q_next};
            state_reg   <= DONE;
          end
        end
        DONE: begin
          state_reg <= DONE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign product = product_reg;
  assign state   = state_reg;

endmodule

// File: tb/tb_booth_mul.sv
// Directed bench for booth_mul (n=5): known products, reset/abort behaviour,
// operand isolation after sampling and DONE hold stability.
module tb_booth_mul;

  logic       clk;
  logic       rst;
  logic [4:0] a;
  logic [4:0] b;
  logic [9:0] product;
  logic [1:0] state;

  int compared   = 0;
  int mismatched = 0;

  booth_mul #(.n(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .product (product),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
    end else begin
      $display("ok   %s: %0h", tag, observed);
    end
  endtask

  // Follow the 6 edges after rst release; optionally scramble operands.
  task automatic observe(input string tag, input logic [9:0] exp_p, input bit scramble);
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) check({tag, " state after edge1"}, 32'(state), 32'h1);
      if (e == 5) begin
        check({tag, " state before done"}, 32'(state), 32'h1);
        check({tag, " product before done"}, 32'(product), 32'h0);
      end
      if (e == 6) begin
        check({tag, " state done"}, 32'(state), 32'h2);
        check({tag, " product"}, 32'(product), 32'(exp_p));
      end
      if (scramble && e < 6) begin
        a = 5'($urandom);
        b = 5'($urandom);
      end
    end
  endtask

  task automatic run_mul(input string tag, input logic [4:0] av, input logic [4:0] bv,
                         input logic [9:0] exp_p, input bit scramble);
    a   = av;
    b   = bv;
    rst = 1'b1;
    @(negedge clk);
    check({tag, " reset state"}, 32'(state), 32'h0);
    check({tag, " reset product"}, 32'(product), 32'h0);
    rst = 1'b0;
    observe(tag, exp_p, scramble);
  endtask

  initial begin
    rst = 1'b1;
    a   = 5'b01110;
    b   = 5'b11011;
    #20;
    check("t1 reset state", 32'(state), 32'h0);
    check("t1 reset product", 32'(product), 32'h0);
    #2 rst = 1'b0;
    observe("t1 14*-5", 10'b1110111010, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("t1 hold product", 32'(product), 32'h3BA);
    end

    run_mul("t2 0*-11",   5'b00000, 5'b10101, 10'h000, 1'b0);
    run_mul("t2 1*-1",    5'b00001, 5'b11111, 10'h3FF, 1'b0);
    run_mul("t3 -16*-16", 5'b10000, 5'b10000, 10'h100, 1'b0);
    run_mul("t4 15*15",   5'b01111, 5'b01111, 10'h0E1, 1'b0);
    run_mul("t4 -16*15",  5'b10000, 5'b01111, 10'h310, 1'b0);
    run_mul("t4 15*-16",  5'b01111, 5'b10000, 10'h310, 1'b0);
    run_mul("t4 -1*-1",   5'b11111, 5'b11111, 10'h001, 1'b0);

    // Abort during the third CALC cycle, checked without a clock edge.
    a   = 5'b00011;
    b   = 5'b00010;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t5 mid-calc state", 32'(state), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("t5 abort state", 32'(state), 32'h0);
    check("t5 abort product", 32'(product), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    observe("t5 3*2", 10'h006, 1'b0);

    run_mul("t6 -7*9 scrambled", 5'b11001, 5'b01001, 10'h3C1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      a = 5'($urandom);
      b = 5'($urandom);
      check("t6 hold product", 32'(product), 32'h3C1);
      check("t6 hold state", 32'(state), 32'h2);
    end

    // Abort from DONE clears the product immediately.
    #2 rst = 1'b1;
    #1;
    check("t6 done abort state", 32'(state), 32'h0);
    check("t6 done abort product", 32'(product), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/booth_mul.md
Name: booth_mul

Overview:
Sequential radix-2 Booth multiplier for signed two's-complement operands. It computes product = a × b over n iterations, one iteration per clock. The reset input doubles as the start control: holding rst high clears the block, and releasing it launches one multiplication. It is a standalone arithmetic block. The 2-bit state output is exposed for sequencing and debug.

Parameters:
n, 5, operand width in bits; product is 2n bits.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset; deassertion starts a multiplication.
a  input  n  multiplicand, signed two's complement.
b  input  n  multiplier, signed two's complement.
product  output  2n  signed result; registered.
state  output  2  current FSM state encoding.

Behaviour:
- Reset: while rst=1, the following are forced to 0 asynchronously: state=IDLE (2'b00), product, accumulator, multiplier register, q_1 and counter.
- States:
  - IDLE=2'b00
  - CALC=2'b01
  - DONE=2'b10
  - 2'b11 is illegal and returns to IDLE on the next edge.
- IDLE, first rising edge with rst=0:
  - M <= a, sign-extended to n+1 bits.
  - Q <= b; A <= 0 ((n+1)-bit accumulator); q_1 <= 0; count <= n.
  - Go to CALC.
- CALC, each edge performs one Booth step:
  - {Q[0],q_1}=01: A+M.
  - {Q[0],q_1}=10: A−M.
  - 00 or 11: A unchanged.
  - Then arithmetic right shift of {A,Q,q_1} by 1, with the MSB of A replicated.
  - count decrements by 1.
  - On the step where count reaches 0, go to DONE and register product <= low 2n bits of {A,Q} after the final shift.
- DONE: product and state hold until rst is asserted. No automatic restart.
- Latency: the product is valid and state=DONE after n+1 rising edges following rst deassertion (6 edges for n=5).
- product reads 0 from reset until DONE.
- Operands are sampled only at the IDLE→CALC edge. Changes to a or b afterwards have no effect.
- The accumulator is n+1 bits, so −M is correct when a is the most-negative value. All n-bit signed pairs give the exact 2n-bit signed product.
- rst asserted mid-CALC or in DONE aborts immediately, with all registers returning to reset values. Release starts a fresh operation with the current a and b.
- There is no overflow flag; the result always fits in 2n bits.

Decomposition:
- Shared package: state encodings IDLE/CALC/DONE as a 2-bit typedef/localparams; a helper constant for the counter width, clog2(n+1).
- One natural sub-module, booth_step: combinational. Inputs are A, Q, q_1 and M; outputs are the next A, Q and q_1 (add/sub select plus arithmetic shift).
- The FSM, counter and product register stay in booth_mul.

Test Plan:
1. n=5, a=01110 (14), b=11011 (−5), rst released at 22 ns with a 10 ns clock → state goes 00→01 on the first edge, 10 on the sixth edge; product=10'b1110111010 (−70), held thereafter.
2. a=0, b=10101 → product=0 at DONE; a=00001, b=11111 → product=10'h3FF (−1).
3. a=10000, b=10000 (−16×−16) → product=10'h100 (+256), checking the n+1-bit accumulator.
4. a=01111, b=01111 → 10'h0E1 (225); a=10000, b=01111 → 10'h310 (−240).
5. Assert rst during the third CALC cycle → state=00 and product=0 immediately, without waiting for a clock. Release with a=00011, b=00010 → product=6 after 6 edges.
6. After the IDLE→CALC edge, change a and b every cycle → result matches the originally sampled operands. Hold DONE for 20 cycles → product and state are stable.
